// File: rtl/uart_status_tx_pkg.sv
// Shared definitions for the UART LED-control link: mode encodings, ASCII
// framing bytes, status message lengths and the reply sequencer states.
package uart_status_tx_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_BREATH = 2'b01,
        MODE_FLOW   = 2'b10,
        MODE_ERR    = 2'b11
    } led_mode_e;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    localparam int unsigned LEN_OFF    = 5;
    localparam int unsigned LEN_BREATH = 8;
    localparam int unsigned LEN_FLOW   = 6;
    localparam int unsigned LEN_ERR    = 5;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_LOAD,
        SEQ_SEND,
        SEQ_WAIT
    } seq_state_e;

    // Index of the final byte (the LF) of the status line for a mode.
    function automatic logic [2:0] msg_last_idx(input led_mode_e mode);
        logic [2:0] last;
        case (mode)
            MODE_OFF:    last = 3'(LEN_OFF - 1);
            MODE_BREATH: last = 3'(LEN_BREATH - 1);
            MODE_FLOW:   last = 3'(LEN_FLOW - 1);
            default:     last = 3'(LEN_ERR - 1);
        endcase
        return last;
    endfunction

endpackage

// File: rtl/uart_status_tx_if.sv
// Host-facing signal bundle of the status reply path.
interface uart_status_tx_if;
    logic [1:0] led_switch;
    logic       report_req;
    logic       busy_flag;
    logic       tx;

    modport master (output led_switch, output report_req, input busy_flag, input tx);
    modport slave  (input led_switch, input report_req, output busy_flag, output tx);
endinterface

// File: rtl/uart_byte_ser.sv
// 8N1 bit serializer: start bit the cycle after start, LSB first, each bit
// held BAUD_CNT_MAX cycles; done is high during the last stop-bit cycle.
module uart_byte_ser #(
    parameter int unsigned BAUD_CNT_MAX = 5208
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);

    localparam int unsigned   CW        = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_CNT_MAX - 1);
    localparam logic [3:0]    BIT_LAST  = 4'd9;

    logic          busy_q, busy_d;
    logic [3:0]    bit_q, bit_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [7:0]    sh_q, sh_d;
    logic          tx_q, tx_d;

    always_comb begin
        busy_d = busy_q;
        bit_d  = bit_q;
        baud_d = baud_q;
        sh_d   = sh_q;
        tx_d   = tx_q;
        if (!busy_q) begin
            if (start) begin
                busy_d = 1'b1;
                bit_d  = '0;
                baud_d = '0;
                sh_d   = data;
                tx_d   = 1'b0;
            end
        end else if (baud_q == BAUD_LAST) begin
            baud_d = '0;
            if (bit_q == BIT_LAST) begin
                busy_d = 1'b0;
                tx_d   = 1'b1;
            end else begin
                bit_d = bit_q + 4'd1;
                // Bit 8 is the last data bit; the next slot is the stop bit.
                if (bit_q == 4'd8) begin
                    tx_d = 1'b1;
                end else begin
                    tx_d = sh_q[0];
                    sh_d = {1'b0, sh_q[7:1]};
                end
            end
        end else begin
            baud_d = baud_q + CW'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            bit_q  <= '0;
            baud_q <= '0;
            sh_q   <= '0;
            tx_q   <= 1'b1;
        end else begin
            busy_q <= busy_d;
            bit_q  <= bit_d;
            baud_q <= baud_d;
            sh_q   <= sh_d;
            tx_q   <= tx_d;
        end
    end

    assign tx   = tx_q;
    assign done = busy_q && (bit_q == BIT_LAST) && (baud_q == BAUD_LAST);

endmodule

// File: rtl/uart_status_tx.sv
// Status reply path: on request or LED mode change, sends the ASCII status
// line for the snapshotted mode as 8N1 frames, with a one-deep pending request.
module uart_status_tx
    import uart_status_tx_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = 50_000_000,
    parameter int unsigned BAUD        = 9600,
    parameter bit          AUTO_REPORT = 1'b1
) (
    input logic             sys_clk,
    input logic             rst_n,
    uart_status_tx_if.slave bus
);

    localparam int unsigned BAUD_CNT_MAX = CLK_FREQ / BAUD;

    seq_state_e state_q, state_d;
    led_mode_e  mode_q, mode_d;
    logic [2:0] idx_q, idx_d;
    logic       pending_q, pending_d;
    logic [1:0] led_prev_q;
    logic       trig_q, trig_d;

    logic       ser_start;
    logic [7:0] ser_data;
    logic       ser_tx;
    logic       ser_done;

    assign trig_d = bus.report_req | (AUTO_REPORT && (bus.led_switch != led_prev_q));

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        // A trigger during a message queues one repeat; reloads consume it.
        if (trig_q && (state_q != SEQ_IDLE)) begin
            pending_d = 1'b1;
        end
        unique case (state_q)
            SEQ_IDLE: begin
                if (trig_q || pending_q) begin
                    mode_d    = led_mode_e'(bus.led_switch);
                    idx_d     = '0;
                    pending_d = 1'b0;
                    state_d   = SEQ_LOAD;
                end
            end
            SEQ_LOAD: state_d = SEQ_SEND;
            SEQ_SEND: begin
                if (ser_done) begin
                    state_d = SEQ_WAIT;
                end
            end
            SEQ_WAIT: begin
                if (idx_q == msg_last_idx(mode_q)) begin
                    if (pending_q || trig_q) begin
                        mode_d    = led_mode_e'(bus.led_switch);
                        idx_d     = '0;
                        pending_d = 1'b0;
                        state_d   = SEQ_LOAD;
                    end else begin
                        state_d = SEQ_IDLE;
                    end
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = SEQ_LOAD;
                end
            end
            default: state_d = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SEQ_IDLE;
            mode_q     <= MODE_OFF;
            idx_q      <= '0;
            pending_q  <= 1'b0;
            led_prev_q <= '0;
            trig_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            idx_q      <= idx_d;
            pending_q  <= pending_d;
            led_prev_q <= bus.led_switch;
            trig_q     <= trig_d;
        end
    end

    always_comb begin
        ser_data = '0;
        case ({mode_q, idx_q})
            {MODE_OFF, 3'd0}:    ser_data = 8'h4F;
            {MODE_OFF, 3'd1}:    ser_data = 8'h46;
            {MODE_OFF, 3'd2}:    ser_data = 8'h46;
            {MODE_OFF, 3'd3}:    ser_data = ASCII_CR;
            {MODE_OFF, 3'd4}:    ser_data = ASCII_LF;
            {MODE_BREATH, 3'd0}: ser_data = 8'h42;
            {MODE_BREATH, 3'd1}: ser_data = 8'h52;
            {MODE_BREATH, 3'd2}: ser_data = 8'h45;
            {MODE_BREATH, 3'd3}: ser_data = 8'h41;
            {MODE_BREATH, 3'd4}: ser_data = 8'h54;
            {MODE_BREATH, 3'd5}: ser_data = 8'h48;
            {MODE_BREATH, 3'd6}: ser_data = ASCII_CR;
            {MODE_BREATH, 3'd7}: ser_data = ASCII_LF;
            {MODE_FLOW, 3'd0}:   ser_data = 8'h46;
            {MODE_FLOW, 3'd1}:   ser_data = 8'h4C;
            {MODE_FLOW, 3'd2}:   ser_data = 8'h4F;
            {MODE_FLOW, 3'd3}:   ser_data = 8'h57;
            {MODE_FLOW, 3'd4}:   ser_data = ASCII_CR;
            {MODE_FLOW, 3'd5}:   ser_data = ASCII_LF;
            {MODE_ERR, 3'd0}:    ser_data = 8'h45;
            {MODE_ERR, 3'd1}:    ser_data = 8'h52;
            {MODE_ERR, 3'd2}:    ser_data = 8'h52;
            {MODE_ERR, 3'd3}:    ser_data = ASCII_CR;
            {MODE_ERR, 3'd4}:    ser_data = ASCII_LF;
            default:             ser_data = '0;
        endcase
    end

    assign ser_start = (state_q == SEQ_LOAD);

    uart_byte_ser #(
        .BAUD_CNT_MAX(BAUD_CNT_MAX)
    ) u_ser (
        .sys_clk(sys_clk),
        .rst_n  (rst_n),
        .start  (ser_start),
        .data   (ser_data),
        .tx     (ser_tx),
        .done   (ser_done)
    );

    assign bus.tx        = ser_tx;
    assign bus.busy_flag = (state_q != SEQ_IDLE) || pending_q;

endmodule

// File: tb/tb_uart_status_tx.sv
// Bench for uart_status_tx: two instances (auto-report on/off) at 10 cycles/bit,
// a per-cycle timing model of the line, a UART decoder, vector table and corner cases.
module tb_uart_status_tx;

    localparam int BITC = 10;
    localparam int SLOT = 102;  // 100-cycle frame plus the WAIT and LOAD gap cycles

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] led = 2'b01;
    logic       req = 1'b0;

    always #5 clk = ~clk;

    uart_status_tx_if ifa ();
    uart_status_tx_if ifn ();

    assign ifa.led_switch = led;
    assign ifa.report_req = req;
    assign ifn.led_switch = led;
    assign ifn.report_req = req;

    uart_status_tx #(.CLK_FREQ(1000), .BAUD(100), .AUTO_REPORT(1'b1)) dut_a (
        .sys_clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    uart_status_tx #(.CLK_FREQ(1000), .BAUD(100), .AUTO_REPORT(1'b0)) dut_n (
        .sys_clk(clk), .rst_n(rst_n), .bus(ifn.slave));

    logic tx_s [2];
    logic busy_s [2];
    assign tx_s[0]   = ifa.tx;
    assign tx_s[1]   = ifn.tx;
    assign busy_s[0] = ifa.busy_flag;
    assign busy_s[1] = ifn.busy_flag;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    function automatic string msg_str(input int m);
        case (m)
            0:       return "OFF\015\012";
            1:       return "BREATH\015\012";
            2:       return "FLOW\015\012";
            default: return "ERR\015\012";
        endcase
    endfunction

    // Reference model: message timeline per instance (0 = auto, 1 = no auto).
    int         busy_end [2] = '{-1, -1};
    int         cur_start [2] = '{-1000000, -1000000};
    int         cur_mode [2] = '{0, 0};
    bit         pending [2] = '{1'b0, 1'b0};
    bit         trig_reg [2] = '{1'b0, 1'b0};
    logic [1:0] hist [2] = '{2'b00, 2'b00};
    string      mlog [2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            busy_end[i]  = -1;
            cur_start[i] = -1000000;
            cur_mode[i]  = 0;
            pending[i]   = 1'b0;
            trig_reg[i]  = 1'b0;
            hist[i]      = 2'b00;
        end
    endtask

    task automatic model_start(input int i, input int c);
        string s;
        cur_start[i] = c;
        cur_mode[i]  = int'(led);
        s            = msg_str(cur_mode[i]);
        busy_end[i]  = c + SLOT * s.len();
        mlog[i]      = {mlog[i], s};
    endtask

    task automatic model_step(input int i, input int c);
        bit t;
        t = trig_reg[i];
        if (c == busy_end[i] && (t || pending[i])) begin
            model_start(i, c);
            pending[i] = 1'b0;
        end else if (t) begin
            if (c > busy_end[i]) model_start(i, c);
            else pending[i] = 1'b1;
        end
        trig_reg[i] = req | ((i == 0) && (led != hist[i]));
        hist[i]     = led;
    endtask

    function automatic logic exp_tx(input int i, input int c);
        int off, k, r, bp;
        string s;
        logic [7:0] b;
        if (c <= cur_start[i] || c > busy_end[i]) return 1'b1;
        off = c - cur_start[i] - 1;
        k   = off / SLOT;
        r   = off % SLOT;
        if (r == 0 || r == SLOT - 1) return 1'b1;
        bp = (r - 1) / BITC;
        if (bp == 0) return 1'b0;
        if (bp == 9) return 1'b1;
        s = msg_str(cur_mode[i]);
        b = 8'(s.getc(k));
        return b[bp-1];
    endfunction

    always @(posedge clk) begin
        if (!rst_n) model_reset();
        else for (int i = 0; i < 2; i++) model_step(i, cyc);
        cyc <= cyc + 1;
    end

    // Line decoder: samples mid-bit after a falling start edge.
    logic [7:0] rxq_a [$];
    logic [7:0] rxq_n [$];
    bit         rx_act [2] = '{1'b0, 1'b0};
    int         rx_cnt [2] = '{0, 0};
    logic [7:0] rx_sh [2];
    logic       et, eb;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                et = 1'b1;
                eb = 1'b0;
                rx_act[i] = 1'b0;
            end else begin
                et = exp_tx(i, cyc);
                eb = (cyc <= busy_end[i]);
                if (!rx_act[i]) begin
                    if (tx_s[i] == 1'b0) begin
                        rx_act[i] = 1'b1;
                        rx_cnt[i] = 0;
                    end
                end else begin
                    rx_cnt[i] = rx_cnt[i] + 1;
                    if (rx_cnt[i] % BITC == 5 && rx_cnt[i] < 90)
                        rx_sh[i][rx_cnt[i] / BITC - 1] = tx_s[i];
                    if (rx_cnt[i] == 95) begin
                        if (i == 0) rxq_a.push_back(rx_sh[i]);
                        else rxq_n.push_back(rx_sh[i]);
                        rx_act[i] = 1'b0;
                    end
                end
            end
            n_cmp++;
            if (tx_s[i] !== et || busy_s[i] !== eb) begin
                n_fail++;
                $display("FAIL line dut%0d cyc=%0d: tx=%b busy=%b, want tx=%b busy=%b",
                         i, cyc, tx_s[i], busy_s[i], et, eb);
            end
        end
    end

    function automatic string hexq(input logic [7:0] q [$]);
        string r = "";
        for (int k = 0; k < q.size() && k < 40; k++) r = {r, $sformatf("%02h ", q[k])};
        return r;
    endfunction

    function automatic string hexs(input string s);
        string r = "";
        for (int k = 0; k < s.len() && k < 40; k++) r = {r, $sformatf("%02h ", 8'(s.getc(k)))};
        return r;
    endfunction

    task automatic cmp_q(input string name, input int i, input string exp);
        logic [7:0] q [$];
        bit ok;
        if (i == 0) q = rxq_a;
        else q = rxq_n;
        ok = (q.size() == exp.len());
        for (int k = 0; k < q.size() && ok; k++)
            if (q[k] != 8'(exp.getc(k))) ok = 1'b0;
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0d bytes [%s] want %0d bytes [%s]",
                     name, i, q.size(), hexq(q), exp.len(), hexs(exp));
        end
    endtask

    task automatic cmp_bit(input string name, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b want %b", name, got, exp);
        end
    endtask

    task automatic clear_rx();
        rxq_a.delete();
        rxq_n.delete();
        mlog[0] = "";
        mlog[1] = "";
    endtask

    task automatic wait_idle();
        int k = 0;
        repeat (4) @(negedge clk);
        while ((busy_s[0] || busy_s[1]) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (k >= 3000) begin
            n_fail++;
            $display("FAIL idle_timeout: busy=%b%b after %0d cycles want 00", busy_s[0], busy_s[1], k);
        end
    endtask

    task automatic pulse(input logic [1:0] l, input logic r);
        @(posedge clk);
        #1 led = l;
        req = r;
        @(posedge clk);
        #1 req = 1'b0;
    endtask

    function automatic string exp_of(input int m);
        return (m < 0) ? "" : msg_str(m);
    endfunction

    typedef struct {
        logic [1:0] led;
        logic       req;
        int         exp_a;
        int         exp_n;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int k;
        int lows;
        tbl[0] = '{2'b01, 1'b1, 1, 1};
        tbl[1] = '{2'b10, 1'b0, 2, -1};
        tbl[2] = '{2'b10, 1'b1, 2, 2};
        tbl[3] = '{2'b11, 1'b0, 3, -1};
        tbl[4] = '{2'b00, 1'b0, 0, -1};
        tbl[5] = '{2'b00, 1'b1, 0, 0};
        tbl[6] = '{2'b01, 1'b0, 1, -1};

        // Reset with led_switch=01: released, the auto instance must report it.
        repeat (3) @(posedge clk);
        #1;
        cmp_bit("reset_tx_a", tx_s[0], 1'b1);
        cmp_bit("reset_busy_a", busy_s[0], 1'b0);
        cmp_bit("reset_tx_n", tx_s[1], 1'b1);
        rst_n = 1'b1;
        wait_idle();
        cmp_q("por_auto", 0, msg_str(1));
        cmp_q("por_noauto", 1, "");
        clear_rx();

        for (int e = 0; e < 7; e++) begin
            pulse(tbl[e].led, tbl[e].req);
            wait_idle();
            cmp_q($sformatf("vec%0d", e), 0, exp_of(tbl[e].exp_a));
            cmp_q($sformatf("vec%0d", e), 1, exp_of(tbl[e].exp_n));
            clear_rx();
        end

        // Mode change during byte 2 of "OFF": message intact, BREATH follows.
        pulse(2'b00, 1'b1);
        k = 0;
        while (rxq_a.size() < 1 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        repeat (30) @(negedge clk);
        @(posedge clk);
        #1 led = 2'b01;
        wait_idle();
        cmp_q("midchange", 0, {msg_str(0), msg_str(1)});
        cmp_q("midchange", 1, msg_str(0));
        clear_rx();

        // Three requests during one ERR message merge into a single repeat.
        pulse(2'b11, 1'b1);
        for (int p = 0; p < 3; p++) begin
            repeat (100) @(posedge clk);
            #1 req = 1'b1;
            @(posedge clk);
            #1 req = 1'b0;
        end
        wait_idle();
        cmp_q("merge", 0, {msg_str(3), msg_str(3)});
        cmp_q("merge", 1, {msg_str(3), msg_str(3)});
        clear_rx();

        // Request in the first idle cycle: tx low three cycles later.
        req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        cmp_bit("lat_c1_a", tx_s[0], 1'b1);
        cmp_bit("lat_c1_n", tx_s[1], 1'b1);
        @(negedge clk);
        cmp_bit("lat_c2_a", tx_s[0], 1'b1);
        cmp_bit("lat_c2_n", tx_s[1], 1'b1);
        @(negedge clk);
        cmp_bit("lat_c3_a", tx_s[0], 1'b0);
        cmp_bit("lat_c3_n", tx_s[1], 1'b0);

        // Reset in the middle of the third data bit of the first frame.
        repeat (35) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        cmp_bit("rst_tx_a", tx_s[0], 1'b1);
        cmp_bit("rst_tx_n", tx_s[1], 1'b1);
        cmp_bit("rst_busy_a", busy_s[0], 1'b0);
        cmp_bit("rst_busy_n", busy_s[1], 1'b0);
        led = 2'b00;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_rx();
        lows = 0;
        repeat (300) begin
            @(negedge clk);
            if (!tx_s[0] || !tx_s[1] || busy_s[0] || busy_s[1]) lows++;
        end
        n_cmp++;
        if (lows != 0) begin
            n_fail++;
            $display("FAIL post_reset_idle: %0d active cycles want 0", lows);
        end
        cmp_q("post_reset", 0, "");

        // Random requests and mode changes against the model's message log.
        clear_rx();
        for (int n = 0; n < 6000; n++) begin
            @(posedge clk);
            #1 req = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 299) == 0) led = 2'($urandom_range(0, 3));
        end
        req = 1'b0;
        wait_idle();
        cmp_q("rand", 0, mlog[0]);
        cmp_q("rand", 1, mlog[1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, cyc=%0d want completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule
